// File: rtl/word_assembler_pkg.sv
// Shared widths and helpers for the SHA-256 word assembler.
package word_assembler_pkg;

  // Message length field width (bytes); length in bits must fit one 32-bit word.
  localparam int PROCB_TOTAL_MSB = 28;
  // Block operation tag width.
  localparam int BLK_OP_MSB      = 1;
  // Words per 64-byte SHA-256 block.
  localparam int WORDS_PER_BLK   = 16;

  // Index of the highest set bit (0 for an argument of 0 or 1).
  function automatic int msb_of(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) r = i;
    end
    return r;
  endfunction

  // Reverse byte order of a 32-bit word.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/word_assembler_byte_select.sv
// Extracts up to four bytes from one dataset, lowest byte position first,
// with unused byte lanes forced to zero.
module word_assembler_byte_select
  import word_assembler_pkg::*;
(
  input  logic [31:0]              in_data,
  input  logic [2:0]               in_len,
  input  logic [1:0]               in_off,
  input  logic                     in_add0x80pad,
  input  logic                     in_add0pad,
  input  logic                     in_add_total,
  input  logic [PROCB_TOTAL_MSB:0] in_total,
  output logic [31:0]              sel_bytes,
  output logic [2:0]               sel_cnt,
  output logic                     sel_err
);

  logic                       len_ok;
  logic [3:0]                 off_end;
  logic [31:0]                len_mask;
  logic [63:0]                data_dbl;
  logic [31:0]                data_rot;
  logic [PROCB_TOTAL_MSB+3:0] bit_len;

  // Choose the byte source; the data path rotates so in_off lands in lane 0,
  // which gives the modulo-4 wrap for free on offset overruns.
  always_comb begin
    len_ok    = (in_len >= 3'd1) && (in_len <= 3'd4);
    off_end   = {2'b00, in_off} + {1'b0, in_len};
    data_dbl  = {in_data, in_data} >> {in_off, 3'b000};
    data_rot  = data_dbl[31:0];
    bit_len   = {in_total, 3'b000};
    case (in_len)
      3'd1:    len_mask = 32'h0000_00FF;
      3'd2:    len_mask = 32'h0000_FFFF;
      3'd3:    len_mask = 32'h00FF_FFFF;
      3'd4:    len_mask = 32'hFFFF_FFFF;
      default: len_mask = 32'h0000_0000;
    endcase

    sel_bytes = 32'h0;
    sel_cnt   = 3'd0;
    sel_err   = 1'b0;
    if (in_add_total) begin
      sel_bytes = byte_swap32(bit_len);
      sel_cnt   = 3'd4;
    end else if (in_add0x80pad) begin
      if (len_ok) begin
        sel_bytes = 32'h0000_0080;
        sel_cnt   = in_len;
      end else begin
        sel_err = 1'b1;
      end
    end else if (in_add0pad) begin
      if (len_ok) begin
        sel_cnt = in_len;
      end else begin
        sel_err = 1'b1;
      end
    end else begin
      if (len_ok) begin
        sel_bytes = data_rot & len_mask;
        sel_cnt   = in_len;
        sel_err   = (off_end > 4'd4);
      end else begin
        sel_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_assembler.sv
// Packs variable-length byte datasets into big-endian 32-bit SHA-256 message
// words, numbering them within 64-byte blocks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT_BLK  | no bytes of the current block seen; next dataset opens it
// FILL      | block open, accumulating bytes until word 15 is emitted
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter int N_THREADS     = 6,
  parameter int N_THREADS_MSB = msb_of(N_THREADS - 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_en,
  input  logic [31:0]              in_data,
  input  logic [2:0]               in_len,
  input  logic [1:0]               in_off,
  input  logic                     in_add0x80pad,
  input  logic                     in_add0pad,
  input  logic                     in_add_total,
  input  logic [PROCB_TOTAL_MSB:0] in_total,
  input  logic                     in_blk_end,
  input  logic [N_THREADS_MSB:0]   in_thread_num,
  input  logic [BLK_OP_MSB:0]      in_blk_op,
  output logic                     out_wr_en,
  output logic [31:0]              out_data,
  output logic [3:0]               out_word_num,
  output logic                     out_blk_end,
  output logic [N_THREADS_MSB:0]   out_thread_num,
  output logic [BLK_OP_MSB:0]      out_blk_op,
  output logic                     err
);

  typedef enum logic {
    ST_WAIT_BLK = 1'b0,
    ST_FILL     = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [23:0]            buf_q, buf_d;
  logic [2:0]             byte_cnt_q, byte_cnt_d;
  logic [3:0]             word_cnt_q, word_cnt_d;
  logic                   err_q, err_d;
  logic [N_THREADS_MSB:0] thr_q, thr_d;
  logic [BLK_OP_MSB:0]    op_q, op_d;

  logic                   wr_q;
  logic [31:0]            data_q;
  logic [3:0]             num_q;
  logic                   end_q;
  logic [N_THREADS_MSB:0] othr_q;
  logic [BLK_OP_MSB:0]    oop_q;

  logic [31:0]            sel_bytes;
  logic [2:0]             sel_cnt;
  logic                   sel_err;
  logic [31:0]            new_bytes;
  logic [2:0]             new_cnt;
  logic [55:0]            comb_flat;
  logic [2:0]             comb_cnt;

  logic                   emit;
  logic                   emit_end;
  logic [31:0]            emit_data;
  logic [N_THREADS_MSB:0] emit_thr;
  logic [BLK_OP_MSB:0]    emit_op;
  logic                   last_word;
  logic                   blk_end_ok;

  word_assembler_byte_select u_byte_select (
    .in_data       (in_data),
    .in_len        (in_len),
    .in_off        (in_off),
    .in_add0x80pad (in_add0x80pad),
    .in_add0pad    (in_add0pad),
    .in_add_total  (in_add_total),
    .in_total      (in_total),
    .sel_bytes     (sel_bytes),
    .sel_cnt       (sel_cnt),
    .sel_err       (sel_err)
  );

  // Append the new bytes behind the held ones; this 7-byte view is the holding
  // buffer, of which at most three bytes survive into the next cycle.
  always_comb begin
    new_bytes = in_en ? sel_bytes : 32'h0;
    new_cnt   = in_en ? sel_cnt : 3'd0;
    comb_flat = ({24'h0, new_bytes} << {byte_cnt_q, 3'b000}) | {32'h0, buf_q};
    comb_cnt  = byte_cnt_q + new_cnt;
  end

  // Block FSM, word emission, counters and protocol error detection.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    thr_d      = thr_q;
    op_d       = op_q;
    emit       = 1'b0;
    emit_end   = 1'b0;
    emit_data  = byte_swap32(comb_flat[31:0]);
    emit_thr   = thr_q;
    emit_op    = op_q;
    last_word  = (word_cnt_q == 4'd15);
    blk_end_ok = last_word && (comb_cnt >= 3'd4);

    if (in_en) begin
      if (state_q == ST_WAIT_BLK) begin
        thr_d    = in_thread_num;
        op_d     = in_blk_op;
        emit_thr = in_thread_num;
        emit_op  = in_blk_op;
        state_d  = ST_FILL;
      end
      if (sel_err) err_d = 1'b1;

      if (in_blk_end && !blk_end_ok) begin
        // Misplaced block end: drop the partial block and resynchronise.
        err_d      = 1'b1;
        buf_d      = 24'h0;
        byte_cnt_d = 3'd0;
        word_cnt_d = 4'd0;
        state_d    = ST_WAIT_BLK;
      end else if (comb_cnt >= 3'd4) begin
        emit       = 1'b1;
        word_cnt_d = word_cnt_q + 4'd1;
        if (last_word) begin
          // Anything past byte 64 belongs to no block and is discarded.
          if (comb_cnt > 3'd4) err_d = 1'b1;
          emit_end   = 1'b1;
          buf_d      = 24'h0;
          byte_cnt_d = 3'd0;
          state_d    = ST_WAIT_BLK;
        end else begin
          buf_d      = comb_flat[55:32];
          byte_cnt_d = comb_cnt - 3'd4;
        end
      end else begin
        buf_d      = comb_flat[23:0];
        byte_cnt_d = comb_cnt;
      end
    end
  end

  // State, buffer, counters and latched block attributes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_WAIT_BLK;
      buf_q      <= 24'h0;
      byte_cnt_q <= 3'd0;
      word_cnt_q <= 4'd0;
      err_q      <= 1'b0;
      thr_q      <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      thr_q      <= thr_d;
      op_q       <= op_d;
    end
  end

  // Registered output word; data and attributes hold between pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q   <= 1'b0;
      data_q <= 32'h0;
      num_q  <= 4'd0;
      end_q  <= 1'b0;
      othr_q <= '0;
      oop_q  <= '0;
    end else begin
      wr_q  <= emit;
      end_q <= emit_end;
      if (emit) begin
        data_q <= emit_data;
        num_q  <= word_cnt_q;
        othr_q <= emit_thr;
        oop_q  <= emit_op;
      end
    end
  end

  assign out_wr_en      = wr_q;
  assign out_data       = data_q;
  assign out_word_num   = num_q;
  assign out_blk_end    = end_q;
  assign out_thread_num = othr_q;
  assign out_blk_op     = oop_q;
  assign err            = err_q;

endmodule

// File: tb/tb_word_assembler.sv
// Bench for word_assembler: byte-queue reference model plus directed block checks.
module tb_word_assembler;
  import word_assembler_pkg::*;

  logic                     CLK = 1'b0;
  logic                     RST = 1'b0;
  logic                     in_en = 1'b0;
  logic [31:0]              in_data = 32'h0;
  logic [2:0]               in_len = 3'd1;
  logic [1:0]               in_off = 2'd0;
  logic                     in_add0x80pad = 1'b0;
  logic                     in_add0pad = 1'b0;
  logic                     in_add_total = 1'b0;
  logic [PROCB_TOTAL_MSB:0] in_total = '0;
  logic                     in_blk_end = 1'b0;
  logic [2:0]               in_thread_num = 3'd0;
  logic [BLK_OP_MSB:0]      in_blk_op = '0;
  logic                     out_wr_en;
  logic [31:0]              out_data;
  logic [3:0]               out_word_num;
  logic                     out_blk_end;
  logic [2:0]               out_thread_num;
  logic [BLK_OP_MSB:0]      out_blk_op;
  logic                     err;

  word_assembler #(.N_THREADS(6)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .in_en          (in_en),
    .in_data        (in_data),
    .in_len         (in_len),
    .in_off         (in_off),
    .in_add0x80pad  (in_add0x80pad),
    .in_add0pad     (in_add0pad),
    .in_add_total   (in_add_total),
    .in_total       (in_total),
    .in_blk_end     (in_blk_end),
    .in_thread_num  (in_thread_num),
    .in_blk_op      (in_blk_op),
    .out_wr_en      (out_wr_en),
    .out_data       (out_data),
    .out_word_num   (out_word_num),
    .out_blk_end    (out_blk_end),
    .out_thread_num (out_thread_num),
    .out_blk_op     (out_blk_op),
    .err            (err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a byte queue and a count of bytes taken by the open block.
  logic [7:0]          mq[$];
  int                  blk_bytes = 0;
  int                  words_in_blk = 0;
  logic [2:0]          cur_thr = 3'd0;
  logic [BLK_OP_MSB:0] cur_op = '0;
  logic                exp_wr = 1'b0;
  logic [31:0]         exp_data = 32'h0;
  logic [3:0]          exp_num = 4'd0;
  logic                exp_end = 1'b0;
  logic [2:0]          exp_thr = 3'd0;
  logic [BLK_OP_MSB:0] exp_op = '0;
  logic                exp_err = 1'b0;

  logic [31:0]         cap_data[16];
  logic                cap_end[16];

  task automatic model_reset();
    mq.delete();
    blk_bytes    = 0;
    words_in_blk = 0;
    exp_wr       = 1'b0;
    exp_end      = 1'b0;
    exp_err      = 1'b0;
  endtask

  task automatic clear_capture();
    for (int i = 0; i < 16; i++) begin
      cap_data[i] = 32'hDEAD_BEEF;
      cap_end[i]  = 1'b0;
    end
  endtask

  // One clock: check what the previous dataset produced, then present the next.
  task automatic cycle(input logic en, input logic [31:0] data, input int len,
                       input int off, input logic p80, input logic p0,
                       input logic tot, input logic [PROCB_TOTAL_MSB:0] total,
                       input logic be, input logic [2:0] thr,
                       input logic [BLK_OP_MSB:0] op);
    logic [7:0]  b[$];
    logic [31:0] bl;
    @(negedge CLK);
    n_checks++;
    if (out_wr_en !== exp_wr) begin
      n_errors++;
      $display("FAIL wr_en got=%b exp=%b t=%0t", out_wr_en, exp_wr, $time);
    end
    if (exp_wr) begin
      n_checks++;
      if (out_data !== exp_data) begin
        n_errors++;
        $display("FAIL data got=%h exp=%h t=%0t", out_data, exp_data, $time);
      end
      n_checks++;
      if (out_word_num !== exp_num) begin
        n_errors++;
        $display("FAIL word_num got=%0d exp=%0d t=%0t", out_word_num, exp_num, $time);
      end
      n_checks++;
      if (out_blk_end !== exp_end) begin
        n_errors++;
        $display("FAIL blk_end got=%b exp=%b t=%0t", out_blk_end, exp_end, $time);
      end
      n_checks++;
      if (out_thread_num !== exp_thr || out_blk_op !== exp_op) begin
        n_errors++;
        $display("FAIL attrs got=%0d/%0d exp=%0d/%0d t=%0t",
                 out_thread_num, out_blk_op, exp_thr, exp_op, $time);
      end
    end
    n_checks++;
    if (err !== exp_err) begin
      n_errors++;
      $display("FAIL err got=%b exp=%b t=%0t", err, exp_err, $time);
    end
    if (out_wr_en === 1'b1) begin
      cap_data[out_word_num] = out_data;
      cap_end[out_word_num]  = out_blk_end;
    end

    in_en         = en;
    in_data       = data;
    in_len        = 3'(len);
    in_off        = 2'(off);
    in_add0x80pad = p80;
    in_add0pad    = p0;
    in_add_total  = tot;
    in_total      = total;
    in_blk_end    = be;
    in_thread_num = thr;
    in_blk_op     = op;

    exp_wr  = 1'b0;
    exp_end = 1'b0;
    if (en) begin
      if (tot) begin
        bl = {total, 3'b000};
        for (int k = 3; k >= 0; k--) b.push_back(bl[8*k +: 8]);
      end else if (p80) begin
        b.push_back(8'h80);
        for (int k = 1; k < len; k++) b.push_back(8'h00);
      end else if (p0) begin
        for (int k = 0; k < len; k++) b.push_back(8'h00);
      end else begin
        for (int k = 0; k < len; k++) b.push_back(data[8*((off + k) % 4) +: 8]);
        if (off + len > 4) exp_err = 1'b1;
      end
      if (blk_bytes == 0) begin
        cur_thr = thr;
        cur_op  = op;
      end
      if (be && (blk_bytes + b.size() < 64)) begin
        exp_err = 1'b1;
        mq.delete();
        blk_bytes    = 0;
        words_in_blk = 0;
      end else begin
        foreach (b[i]) begin
          if (blk_bytes < 64) begin
            mq.push_back(b[i]);
            blk_bytes++;
          end else begin
            exp_err = 1'b1;
          end
        end
        if (mq.size() >= 4) begin
          exp_data = {mq[0], mq[1], mq[2], mq[3]};
          repeat (4) void'(mq.pop_front());
          exp_wr  = 1'b1;
          exp_num = 4'(words_in_blk);
          exp_thr = cur_thr;
          exp_op  = cur_op;
          words_in_blk++;
          exp_end = (words_in_blk == WORDS_PER_BLK);
          if (exp_end) begin
            words_in_blk = 0;
            blk_bytes    = 0;
            mq.delete();
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0, '0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST   = 1'b1;
    in_en = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #1;
    n_checks++;
    if ({out_wr_en, out_blk_end, err} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags got=%b exp=000", {out_wr_en, out_blk_end, err});
    end
    n_checks++;
    if (out_data !== 32'h0 || out_word_num !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", out_data, out_word_num);
    end
    n_checks++;
    if (out_thread_num !== 3'd0 || out_blk_op !== '0) begin
      n_errors++;
      $display("FAIL reset_attrs got=%0d/%0d exp=0/0", out_thread_num, out_blk_op);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_counting();
    logic [31:0] d;
    do_reset();
    clear_capture();
    for (int k = 0; k < 64; k++) begin
      d = 32'(k) << (8 * (k % 4));
      cycle(1'b1, d, 1, k % 4, 1'b0, 1'b0, 1'b0, '0, (k == 63), 3'd2, 2'd1);
    end
    idle(2);
    n_checks++;
    if (cap_data[0] !== 32'h0001_0203) begin
      n_errors++;
      $display("FAIL count_word0 got=%h exp=00010203", cap_data[0]);
    end
    n_checks++;
    if (cap_data[15] !== 32'h3C3D_3E3F || cap_end[15] !== 1'b1) begin
      n_errors++;
      $display("FAIL count_word15 got=%h/%b exp=3c3d3e3f/1", cap_data[15], cap_end[15]);
    end
  endtask

  task automatic test_pack();
    do_reset();
    cycle(1'b1, 32'h00CC_BBAA, 3, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd1, 2'd0);
    cycle(1'b1, 32'h00FF_EEDD, 3, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd5, 2'd0);
    cycle(1'b1, 32'h0000_2211, 2, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd5, 2'd0);
    n_checks++;
    if (out_wr_en !== 1'b1 || out_data !== 32'hAABB_CCDD) begin
      n_errors++;
      $display("FAIL pack_w0 got=%b/%h exp=1/aabbccdd", out_wr_en, out_data);
    end
    idle(1);
    n_checks++;
    if (out_wr_en !== 1'b1 || out_data !== 32'hEEFF_1122) begin
      n_errors++;
      $display("FAIL pack_w1 got=%b/%h exp=1/eeff1122", out_wr_en, out_data);
    end
    idle(1);
  endtask

  task automatic test_padding();
    do_reset();
    clear_capture();
    cycle(1'b1, 32'h0063_6261, 3, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd3, 2'd2);
    cycle(1'b1, 32'h0, 1, 0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 3'd0, 2'd0);
    repeat (14) cycle(1'b1, 32'h0, 4, 0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 3'd0, 2'd0);
    cycle(1'b1, 32'h0, 4, 0, 1'b0, 1'b0, 1'b1, 29'd3, 1'b1, 3'd0, 2'd0);
    idle(2);
    n_checks++;
    if (cap_data[0] !== 32'h6162_6380) begin
      n_errors++;
      $display("FAIL pad_word0 got=%h exp=61626380", cap_data[0]);
    end
    n_checks++;
    if (cap_data[14] !== 32'h0) begin
      n_errors++;
      $display("FAIL pad_word14 got=%h exp=00000000", cap_data[14]);
    end
    n_checks++;
    if (cap_data[15] !== 32'h0000_0018 || cap_end[15] !== 1'b1) begin
      n_errors++;
      $display("FAIL pad_word15 got=%h/%b exp=00000018/1", cap_data[15], cap_end[15]);
    end
  endtask

  task automatic test_blk_end_early();
    do_reset();
    for (int k = 0; k < 15; k++)
      cycle(1'b1, $urandom(), 4, 0, 1'b0, 1'b0, 1'b0, '0, (k == 14), 3'd4, 2'd3);
    cycle(1'b1, 32'h4433_2211, 4, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd1, 2'd1);
    idle(1);
    n_checks++;
    if (err !== 1'b1 || out_wr_en !== 1'b1 || out_word_num !== 4'd0) begin
      n_errors++;
      $display("FAIL early_end got=err%b wr%b num%0d exp=err1 wr1 num0",
               err, out_wr_en, out_word_num);
    end
    idle(1);
  endtask

  task automatic test_off_err();
    do_reset();
    cycle(1'b1, 32'hDDCC_BBAA, 2, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0, 2'd0);
    cycle(1'b1, 32'h0000_FFEE, 2, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0, 2'd0);
    idle(1);
    n_checks++;
    if (err !== 1'b1 || out_data !== 32'hDDAA_EEFF) begin
      n_errors++;
      $display("FAIL off_wrap got=err%b %h exp=err1 ddaaeeff", err, out_data);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++)
      cycle(1'b1, $urandom(), 4, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd2, 2'd2);
    cycle(1'b1, $urandom(), 2, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd2, 2'd2);
    #2;
    RST   = 1'b1;
    in_en = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_checks++;
      if (out_wr_en !== 1'b0 || out_word_num !== 4'd0) begin
        n_errors++;
        $display("FAIL rst_hold got=wr%b num%0d exp=wr0 num0", out_wr_en, out_word_num);
      end
    end
    RST = 1'b0;
    cycle(1'b1, 32'h0D0C_0B0A, 4, 0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd3, 2'd1);
    n_checks++;
    if (out_wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_after got=%b exp=0", out_wr_en);
    end
    idle(1);
    n_checks++;
    if (out_wr_en !== 1'b1 || out_word_num !== 4'd0 || err !== 1'b0 ||
        out_data !== 32'h0A0B_0C0D) begin
      n_errors++;
      $display("FAIL rst_restart got=wr%b num%0d err%b %h exp=wr1 num0 err0 0a0b0c0d",
               out_wr_en, out_word_num, err, out_data);
    end
    idle(1);
  endtask

  // Legal random blocks, partly back-to-back across block boundaries.
  task automatic test_random();
    int left, len, off, kind;
    do_reset();
    for (int blk = 0; blk < 8; blk++) begin
      left = 64;
      while (left > 0) begin
        kind = $urandom_range(0, 9);
        len  = $urandom_range(1, (left < 4) ? left : 4);
        off  = $urandom_range(0, 4 - len);
        if (kind == 9 && left >= 4) begin
          left -= 4;
          cycle(1'b1, $urandom(), 4, 0, 1'b0, 1'b0, 1'b1,
                29'($urandom()), (left == 0) && ($urandom_range(0, 1) == 1),
                3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
        end else begin
          left -= len;
          cycle(1'b1, $urandom(), len, off, (kind == 7), (kind >= 7), 1'b0, '0,
                (left == 0) && ($urandom_range(0, 1) == 1),
                3'($urandom_range(0, 5)), 2'($urandom_range(0, 3)));
        end
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_counting();
    test_pack();
    test_padding();
    test_random();
    test_off_err();
    test_blk_end_early();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001: Parameter N_THREADS, default 6, number of hardware threads.
REQ-002: Parameter N_THREADS_MSB, default `MSB(N_THREADS-1), thread number MSB.
REQ-003: CLK  input  1  sole clock; all logic on posedge.
REQ-004: RST  input  1  reset, asynchronous, active-high.
REQ-005: in_en  input  1  dataset valid; one dataset per cycle; memory read data already aligned to this cycle.
REQ-006: in_data  input  32  memory word; byte k at bits [8k+7:8k].
REQ-007: in_len  input  3  byte count of dataset, 1..4.
REQ-008: in_off  input  2  first byte index within in_data.
REQ-009: in_add0x80pad, in_add0pad, in_add_total  input  1 each  padding/total selectors.
REQ-010: in_total  input  `PROCB_TOTAL_MSB+1  message length in bytes.
REQ-011: in_blk_end  input  1  dataset is last of a 64-byte block.
REQ-012: in_thread_num  input  N_THREADS_MSB+1;  in_blk_op  input  `BLK_OP_MSB+1.
REQ-013: out_wr_en  output  1  out_data valid for one cycle.
REQ-014: out_data  output  32  big-endian SHA-256 message word.
REQ-015: out_word_num  output  4  word index 0..15 within block.
REQ-016: out_blk_end  output  1  pulses with word 15.
REQ-017: out_thread_num, out_blk_op  output  as inputs  block attributes, valid with out_wr_en.
REQ-018: err  output  1  sticky protocol error.

Function
REQ-019: Byte source: add_total -> 4 bytes of (in_total<<3) MSB first; add0x80pad (with add0pad) -> 0x80 then in_len-1 zero bytes; add0pad alone -> in_len zero bytes; none -> in_data bytes in_off..in_off+in_len-1, ascending.
REQ-020: in_off+in_len>4 on a data dataset -> err=1; bytes still taken modulo-4 wrap.
REQ-021: Bytes appended in order to a 7-byte holding buffer; byte_cnt 0..7 tracks fill.
REQ-022: When byte_cnt>=4, oldest 4 bytes emitted as one word next cycle, first byte at out_data[31:24]; remainder shifts down same cycle as new bytes append.
REQ-023: Latency in_en -> out_wr_en: exactly 1 cycle when word completes; throughput one word per cycle, no backpressure.
REQ-024: word_cnt 4-bit counter, increments per emitted word, wraps 15->0; out_word_num=word_cnt before increment.
REQ-025: FSM WAIT_BLK: word_cnt==0 and byte_cnt==0; first in_en latches in_thread_num/in_blk_op, -> FILL.
REQ-026: FSM FILL: accumulate; emission of word 15 asserts out_blk_end, -> WAIT_BLK.
REQ-027: in_blk_end must coincide with the dataset completing byte 64; otherwise err=1, buffer and word_cnt cleared, -> WAIT_BLK.
REQ-028: Bytes beyond 64 in a block (byte_cnt overflow) -> err=1, excess discarded.
REQ-029: Emission of word 15 and first dataset of next block in same cycle: next block's attributes latched, its bytes start at word 0 without gap.
REQ-030: err clears only on RST.

Reset
REQ-031: RST clears: out_wr_en, out_blk_end, err, out_data, out_word_num, out_thread_num, out_blk_op to 0; byte_cnt, word_cnt to 0; FSM to WAIT_BLK.
REQ-032: RST mid-block discards partial words; no output pulse during or one cycle after RST.

Structure
REQ-033: `PROCB_TOTAL_MSB, `BLK_OP_MSB, `MSB from shared sha256.vh; FSM state localparams local.
REQ-034: One sub-module natural: byte_select (combinational 4-byte extraction per REQ-019).

Verification
REQ-035: 64 data datasets len=1 off=0..3 rotating, bytes 0x00..0x3F -> 16 words, word0=0x00010203, word15=0x3C3D3E3F, out_blk_end with word15.
REQ-036: len 3,3,2 bytes AA BB CC/DD EE FF/11 22 -> words 0xAABBCCDD, 0xEEFF1122 one cycle after completing datasets.
REQ-037: 3 data bytes, 0x80pad len1, zero pads to byte 56, 4 zero bytes, total=3 -> word14=0, word15=0x00000018, word0=0x61626380-style first word.
REQ-038: in_blk_end at byte 60 -> err=1, next block starts word_num 0.
REQ-039: in_off=3 in_len=2 -> err=1.
REQ-040: RST asserted after 5 words -> no outputs; post-reset block starts word_num 0, err=0.
